// File: rtl/fball_pkg.sv
// Shared constants and types for the fireball sprite fetch path.
package fball_pkg;
   localparam int SPR_W  = 21;
   localparam int SPR_H  = 21;
   localparam int ADDR_W = 9;

   typedef logic [23:0] rgb_t;

   localparam rgb_t KEY_COLOR = 24'h800080;

   typedef enum logic {ANIM_DOWN = 1'b0, ANIM_UP = 1'b1} anim_e;
endpackage

// File: rtl/fball_anim_ctr.sv
// Frame-paced animation toggle: flips anim_sel every FRAMES_PER_STEP frame_start pulses.
import fball_pkg::*;

module fball_anim_ctr #(
   parameter int FRAMES_PER_STEP = 4
) (
   input  logic  clk,
   input  logic  reset,
   input  logic  frame_start,
   input  logic  en,
   output anim_e anim_sel
);
   // A one-frame step still needs a 1-bit counter so the vector is legal.
   localparam int CNT_W = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAMES_PER_STEP - 1);

   logic [CNT_W-1:0] frame_cnt;

   // Count frame_start pulses while the sprite is alive; a dead sprite restarts the count and freezes the frame.
   always_ff @(posedge clk) begin
      if (reset) begin
         frame_cnt <= '0;
         anim_sel  <= ANIM_DOWN;
      end else if (frame_start) begin
         if (!en) begin
            frame_cnt <= '0;
         end else if (frame_cnt == CNT_LAST) begin
            frame_cnt <= '0;
            anim_sel  <= anim_e'(~anim_sel);
         end else begin
            frame_cnt <= frame_cnt + 1'b1;
         end
      end
   end
endmodule

// File: rtl/fball_sprite_fetch.sv
// Fireball layer fetch: box hit-test, ROM addressing, frame select and key-colour masking, 2-cycle latency.
import fball_pkg::*;

module fball_sprite_fetch #(
   parameter int FRAMES_PER_STEP = 4
) (
   input  logic              Clk,
   input  logic              Reset,
   input  logic              frame_start,
   input  logic [9:0]        DrawX,
   input  logic [9:0]        DrawY,
   input  logic [9:0]        FballX,
   input  logic [9:0]        FballY,
   input  logic              fball_en,
   output logic [ADDR_W-1:0] rom_addr,
   input  rgb_t              rom_color_down,
   input  rgb_t              rom_color_up,
   output logic              anim_sel,
   output logic              pix_valid,
   output rgb_t              pix_color
);
   logic [9:0]        sx, sy;
   logic              sen;
   logic signed [10:0] dx, dy;
   logic              hit0;
   logic [ADDR_W-1:0] addr0;
   logic              hit1;
   anim_e             sel1;
   anim_e             anim_st;
   rgb_t              c;
   logic              pv_next;

   fball_anim_ctr #(.FRAMES_PER_STEP(FRAMES_PER_STEP)) u_anim (
      .clk         (Clk),
      .reset       (Reset),
      .frame_start (frame_start),
      .en          (fball_en),
      .anim_sel    (anim_st)
   );

   assign anim_sel = anim_st;

   // Position/enable only move on frame_start so the sprite never tears mid-frame.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         sx  <= '0;
         sy  <= '0;
         sen <= 1'b0;
      end else if (frame_start) begin
         sx  <= FballX;
         sy  <= FballY;
         sen <= fball_en;
      end
   end

   // Stage 0: signed offsets into the box; negative offsets are misses, so no wrap at the screen edge.
   always_comb begin
      dx    = $signed({1'b0, DrawX}) - $signed({1'b0, sx});
      dy    = $signed({1'b0, DrawY}) - $signed({1'b0, sy});
      hit0  = sen && !dx[10] && (dx[9:0] < 10'(SPR_W)) && !dy[10] && (dy[9:0] < 10'(SPR_H));
      addr0 = ADDR_W'(dy[9:0]) * ADDR_W'(SPR_W) + ADDR_W'(dx[9:0]);
   end

   // Stage 1: present the ROM address; misses park the ROM at 0.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         rom_addr <= '0;
         hit1     <= 1'b0;
         sel1     <= ANIM_DOWN;
      end else begin
         rom_addr <= hit0 ? addr0 : '0;
         hit1     <= hit0;
         sel1     <= anim_st;
      end
   end

   // Stage 2 select: pick the frame that was current when the pixel entered, drop key-colour texels.
   always_comb begin
      c       = (sel1 == ANIM_UP) ? rom_color_up : rom_color_down;
      pv_next = hit1 && (c != KEY_COLOR);
   end

   // Stage 2 register: colour is forced to 0 whenever the pixel is not drawn.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         pix_valid <= 1'b0;
         pix_color <= '0;
      end else begin
         pix_valid <= pv_next;
         pix_color <= pv_next ? c : '0;
      end
   end
endmodule
